// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencing one full-adder cell LSB-first
module cmos_fullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, nxt;
    logic [WIDTH-1:0] sa, sb, ps;
    logic [CW-1:0] cnt;
    logic c, fs, fc, load, last;

    cmos_fullAdder fa (.a(sa[0]), .b(sb[0]), .c(c), .s(fs), .co(fc));

    // next state and handshake outputs; start is only honoured outside RUN
    always_comb begin
        load = start && state != RUN;
        last = state == RUN && cnt == CW'(WIDTH - 1);
        busy = state == RUN;
        done = state == DONE;
        nxt  = load ? RUN : last ? DONE : state == RUN ? RUN : IDLE;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // operand capture, one bit per clock, and result load on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            ps   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= sub ? ~b : b;
            c   <= sub ? 1'b1 : cin;
            cnt <= '0;
            ps  <= '0;
        end else if (state == RUN) begin
            ps  <= {fs, ps[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            c   <= fc;
            cnt <= cnt + 1'b1;
            if (last) begin
                sum  <= {fs, ps[WIDTH-1:1]};
                cout <= fc;
                ovf  <= c ^ fc;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks against an arithmetic reference model
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 0, rst = 1, start = 0, sub = 0, cin = 0;
    logic [W-1:0] a = 0, b = 0;
    logic busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_chk = 0, n_fail = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: remaining cycles of the current op and the arithmetic result
    int m_left = 0;
    logic m_done = 0, m_cout = 0, m_ovf = 0, p_cout = 0, p_ovf = 0;
    logic [W-1:0] m_sum = 0, p_sum = 0;
    logic [W:0] full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
                end
            end else if (start) begin
                full = sub ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b} + {8'd0, cin};
                p_sum  = full[W-1:0];
                p_cout = full[W];
                p_ovf  = sub ? (a[W-1] != b[W-1] && full[W-1] != a[W-1])
                             : (a[W-1] == b[W-1] && full[W-1] != a[W-1]);
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_left > 0);
        chk("done", done, m_done);
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        chk("ovf", ovf, m_ovf);
        chk("busy_done_excl", busy & done, 0);
    end

    task automatic go(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xs);
        a = xa; b = xb; cin = xc; sub = xs; start = 1;
        @(negedge clk);
        start = 0; a = 8'hAA; b = 8'h55; cin = ~xc; sub = ~xs;
    endtask

    task automatic wait_done(input string name);
        int n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk({name, "_latency"}, n, W + 1);
    endtask

    task automatic op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input logic xs,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        go(xa, xb, xc, xs);
        wait_done(name);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"}, ovf, eo);
        @(negedge clk);
        chk({name, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        rst = 0;
        @(negedge clk);

        op("add1", 8'h3C, 8'h0A, 0, 0, 8'h46, 0, 0);
        op("wrap", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
        op("sovf", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        op("cin", 8'h00, 8'h00, 1, 0, 8'h01, 0, 0);
        op("sub1", 8'h05, 8'h07, 1, 1, 8'hFE, 0, 0);
        op("sub2", 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);

        go(8'h01, 8'h02, 0, 0);
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1;
        @(negedge clk);
        start = 0;
        pulses = 0;
        repeat (12) begin @(negedge clk); if (done) pulses++; end
        chk("ign_sum", sum, 8'h03);
        chk("ign_pulses", pulses, 1);

        go(8'h55, 8'h11, 0, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 0;
        pulses = 0;
        repeat (10) begin @(negedge clk); if (done) pulses++; end
        chk("arst_nodone", pulses, 0);
        op("post_rst", 8'h10, 8'h20, 0, 0, 8'h30, 0, 0);

        go(8'h02, 8'h02, 0, 0);
        wait_done("b2b1");
        chk("b2b1_sum", sum, 8'h04);
        go(8'h01, 8'h01, 0, 0);
        chk("b2b_nogap", busy, 1);
        wait_done("b2b2");
        chk("b2b2_sum", sum, 8'h02);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
